// File: rtl/pll_ce_sequencer.sv
// Lock-qualified reset sequencer and phase-offset pixel clock-enable divider
// for the consumer side of the core PLL.
module pll_ce_sequencer #(
  parameter int unsigned DIV         = 8,
  parameter int unsigned PH_Q        = 2,
  parameter int unsigned PH_H        = 4,
  parameter int unsigned LOCK_STABLE = 1024,
  parameter int unsigned RST_HOLD    = 16
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       clr_count,
  output logic       ce_pix,
  output logic       ce_pix_q,
  output logic       ce_pix_h,
  output logic       core_reset_n,
  output logic       running,
  output logic [7:0] lock_lost_count
);

  localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
  localparam int unsigned HW = $clog2(RST_HOLD + 1);
  localparam int unsigned DW = $clog2(DIV);

  localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [DW-1:0] POS_Q     = DW'(PH_Q);
  localparam logic [DW-1:0] POS_H     = DW'(PH_H);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABILIZE,
    HOLD_RST,
    RUN
  } state_t;

  state_t        state;
  logic          lock_meta;
  logic          lock_s;
  logic [SW-1:0] stab_cnt;
  logic [HW-1:0] hold_cnt;
  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  always_comb begin
    div_nxt = div_cnt + 1'b1;
    if (div_cnt == DIV_LAST) div_nxt = '0;
  end

  // Strobes are registered from the divider's next value so each pulse lines
  // up with the div_cnt position it decodes; entry to RUN preloads position 0.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state           <= WAIT_LOCK;
      stab_cnt        <= '0;
      hold_cnt        <= '0;
      div_cnt         <= '0;
      ce_pix          <= 1'b0;
      ce_pix_q        <= 1'b0;
      ce_pix_h        <= 1'b0;
      core_reset_n    <= 1'b0;
      running         <= 1'b0;
      lock_lost_count <= '0;
    end else begin
      ce_pix   <= 1'b0;
      ce_pix_q <= 1'b0;
      ce_pix_h <= 1'b0;
      if (clr_count) lock_lost_count <= '0;

      unique case (state)
        WAIT_LOCK: begin
          stab_cnt     <= '0;
          hold_cnt     <= '0;
          div_cnt      <= '0;
          core_reset_n <= 1'b0;
          running      <= 1'b0;
          if (lock_s) state <= STABILIZE;
        end
        STABILIZE: begin
          if (!lock_s) begin
            state    <= WAIT_LOCK;
            stab_cnt <= '0;
          end else if (stab_cnt == STAB_LAST) begin
            state    <= HOLD_RST;
            stab_cnt <= '0;
            hold_cnt <= '0;
          end else begin
            stab_cnt <= stab_cnt + 1'b1;
          end
        end
        HOLD_RST: begin
          if (!lock_s) begin
            state    <= WAIT_LOCK;
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state        <= RUN;
            hold_cnt     <= '0;
            div_cnt      <= '0;
            core_reset_n <= 1'b1;
            running      <= 1'b1;
            ce_pix       <= 1'b1;
            ce_pix_q     <= (POS_Q == '0);
            ce_pix_h     <= (POS_H == '0);
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state        <= WAIT_LOCK;
            div_cnt      <= '0;
            core_reset_n <= 1'b0;
            running      <= 1'b0;
            if (clr_count) begin
              lock_lost_count <= 8'd1;
            end else if (lock_lost_count != 8'hff) begin
              lock_lost_count <= lock_lost_count + 8'd1;
            end
          end else begin
            div_cnt  <= div_nxt;
            ce_pix   <= (div_nxt == '0);
            ce_pix_q <= (div_nxt == POS_Q);
            ce_pix_h <= (div_nxt == POS_H);
          end
        end
        default: state <= WAIT_LOCK;
      endcase
    end
  end

endmodule
